fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage for the RISC-V datapath: owns the PC, issues word reads to instruction memory over a hold-until-valid handshake, latches the returned word into the instruction register and presents it with decoded register/opcode fields to the decode stage over a valid/ready handshake. Unlike the fixed single-cycle PC+4 loop, it supports variable memory latency, back-pressure, branch/jump redirect with in-flight discard, misalignment and timeout faults, and a fetched-instruction counter.

## Interface
- XLEN, 64, PC and address width (≥32)
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
- TIMEOUT, 16, max wait cycles for mem_valid before fault; 0 disables timeout
- CNT_W, 32, width of fetch_count

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  XLEN  byte address of request (= pc)
- mem_rdata  in  32  instruction word, valid with mem_valid
- mem_valid  in  1  response strobe, sampled only while mem_req=1
- ir_valid  out  1  instruction available to decode
- ir_ready  in  1  decode accepts instruction
- ir  out  32  latched instruction (i31_0)
- i19_15, i24_20, i11_7  out  5 each  rs1, rs2, rd fields of ir
- i6_0  out  7  opcode field of ir
- ir_pc  out  XLEN  address the current ir was fetched from
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  XLEN  target address
- fault  out  1  sticky: misaligned redirect or timeout
- fault_cause  out  1  0 = misaligned, 1 = timeout; valid while fault=1
- fetch_count  out  CNT_W  instructions handed to decode

## Operation
- States: FETCH, HOLD, DISCARD, FAULT. Reset state FETCH.
- FETCH: mem_req=1, mem_addr=pc, both held stable until a cycle with mem_valid=1 (zero-wait: mem_valid in same cycle as first mem_req is legal). On mem_valid: ir<=mem_rdata, ir_pc<=pc, pc<=pc+4, go HOLD.
- HOLD: mem_req=0, ir_valid=1. On ir_ready: fetch_count+1, go FETCH.
- DISCARD: mem_req=1 with old address held until mem_valid; data dropped; then FETCH at current pc.
- FAULT: mem_req=0, ir_valid=0, fault=1. Exit only via aligned redirect (-> FETCH) or reset.
- Redirect (priority over everything), with redirect_pc[1:0]==0: pc<=redirect_pc; ir_valid low next cycle; fault cleared.
  - from HOLD: go FETCH; if ir_ready same cycle the handshake still counts (fetch_count+1).
  - from FETCH with mem_valid same cycle: data dropped, go FETCH.
  - from FETCH without mem_valid, or from DISCARD: go DISCARD.
  - from FAULT: go FETCH.
- Redirect with redirect_pc[1:0]!=0: pc unchanged, fault=1, fault_cause=0, go FAULT (if a request is outstanding it is abandoned; memory must tolerate request drop).
- Timeout: wait counter counts cycles with mem_req=1 and mem_valid=0 (FETCH or DISCARD); cleared on mem_valid or state change. Reaching TIMEOUT: fault=1, fault_cause=1, go FAULT. TIMEOUT=0: never.
- pc+4 wraps modulo 2^XLEN; fetch_count wraps modulo 2^CNT_W.
- Field outputs are pure slices of ir: i19_15=ir[19:15], i24_20=ir[24:20], i11_7=ir[11:7], i6_0=ir[6:0].

## Timing
- Reset (rst=0): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, mem_req=0, fault=0, fault_cause=0, fetch_count=0, wait counter=0, state FETCH. First mem_req=1 in first cycle after rst rises.
- Reset mid-transaction: all state cleared immediately; any pending response ignored.
- Latency: mem_valid at edge N -> ir_valid=1 from N+1. Back-to-back throughput with zero-wait memory and ir_ready=1: one instruction per 2 cycles.
- ir, ir_pc, ir_valid are registered; stable while ir_valid=1 and ir_ready=0.
- Redirect at edge N -> mem_addr=redirect_pc from N+1 (FETCH) or after the discarded response (DISCARD).

## Test plan
- Reset, RESET_PC=0x1000, zero-wait memory, ir_ready=1 -> mem_addr 0x1000,0x1004,0x1008; ir_valid every other cycle; fetch_count=3 after third handshake; ir=0x00A28293 gives i19_15=5, i24_20=10, i11_7=5, i6_0=0x13.
- Memory 3 wait cycles, ir_ready held 0 for 4 cycles -> mem_addr/mem_req stable during wait; ir stable and fetch_count unchanged until ready.
- Redirect to 0x2000 during outstanding request -> DISCARD, old response (0xDEADBEEF) never appears on ir; next mem_addr=0x2000, ir_pc=0x2000.
- Redirect to 0x2002 -> fault=1, fault_cause=0, mem_req=0; then redirect to 0x3000 -> fault=0, fetch at 0x3000.
- TIMEOUT=4, memory never responds -> fault=1, fault_cause=1 after 4 wait cycles; rst low mid-wait clears all outputs to reset values.
- RESET_PC=2^XLEN-4 -> second fetch address 0; CNT_W=4 -> fetch_count wraps 15->0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage with variable-latency memory, back-pressure, redirect and faults
//   clk, rst                        clock, asynchronous active-low reset
//   mem_req/mem_addr                read request, held stable until mem_valid
//   mem_rdata/mem_valid             instruction word and response strobe
//   ir_valid/ir_ready               handshake to decode
//   ir/ir_pc/i19_15/i24_20/i11_7/i6_0  latched instruction, its address and field slices
//   redirect_valid/redirect_pc      branch/jump target
//   fault/fault_cause/fetch_count   sticky fault (0 misaligned, 1 timeout) and handed-off count
module fetch_unit #(
    parameter int unsigned XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_valid,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [31:0]      ir,
    output logic [4:0]       i19_15,
    output logic [4:0]       i24_20,
    output logic [4:0]       i11_7,
    output logic [6:0]       i6_0,
    output logic [XLEN-1:0]  ir_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             fault,
    output logic             fault_cause,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD, FAULT} state_t;
    localparam int unsigned TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t state, nxt;
    logic [XLEN-1:0] pc, old_addr;
    logic [TW-1:0] wcnt;
    logic misal, waiting, tmo, take;
    assign misal = redirect_pc[1:0] != 2'b00;
    assign waiting = mem_req && !mem_valid;
    assign tmo = TIMEOUT != 0 && waiting && wcnt == TW'(TIMEOUT - 1);
    assign take = state == FETCH && mem_valid && !redirect_valid;
    assign i19_15 = ir[19:15];
    assign i24_20 = ir[24:20];
    assign i11_7 = ir[11:7];
    assign i6_0 = ir[6:0];
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= FETCH;
        else state <= nxt;
    // An aligned redirect with a request still outstanding must drain that response first.
    always_comb begin
        nxt = state;
        if (redirect_valid) nxt = misal ? FAULT : (waiting ? DISCARD : FETCH);
        else if (tmo) nxt = FAULT;
        else if (state == FETCH && mem_valid) nxt = HOLD;
        else if (state == HOLD && ir_ready) nxt = FETCH;
        else if (state == DISCARD && mem_valid) nxt = FETCH;
    end
    // mem_req is gated by rst so no request is visible while reset is asserted.
    always_comb begin
        mem_req = rst && (state == FETCH || state == DISCARD);
        mem_addr = state == DISCARD ? old_addr : pc;
        ir_valid = state == HOLD;
        fault = state == FAULT;
    end
    // old_addr follows pc while fetching, so it holds the abandoned address once DISCARD is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            old_addr <= RESET_PC;
            ir <= '0;
            ir_pc <= '0;
            fault_cause <= 1'b0;
            fetch_count <= '0;
            wcnt <= '0;
        end else begin
            if (state == FETCH) old_addr <= pc;
            if (redirect_valid && !misal) pc <= redirect_pc;
            else if (take) pc <= pc + XLEN'(4);
            if (take) begin
                ir <= mem_rdata;
                ir_pc <= pc;
            end
            if (state == HOLD && ir_ready) fetch_count <= fetch_count + 1'b1;
            if (redirect_valid && misal) fault_cause <= 1'b0;
            else if (!redirect_valid && tmo) fault_cause <= 1'b1;
            wcnt <= (waiting && nxt == state) ? wcnt + 1'b1 : '0;
        end
    end
endmodule
